// File: rtl/alu_input_ctrl.sv
// Input stage ahead of the ALU: synchronises and debounces the three load buttons,
// captures the switch bus into operand/opcode registers and strobes start on an opcode load.
module alu_input_ctrl #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OP           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [2:0]         o_loaded,
    output logic               o_valid,
    output logic               o_start
);

    localparam int unsigned NumBtn  = 3;
    localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NumBtn-1:0] btnRaw;
    logic [NumBtn-1:0] syncS1;
    logic [NumBtn-1:0] syncS2;
    logic [NumBtn-1:0] debLevel;
    logic [CntW-1:0]   debCnt [NumBtn];

    logic [NumBtn-1:0] pressC;
    logic              loadA;
    logic              loadB;
    logic              loadOp;
    logic [2:0]        loadedNext;

    assign btnRaw = {i_btn_op, i_btn_b, i_btn_a};

    // Two-flop synchroniser plus per-button stability counter
    always_ff @(posedge clock) begin
        if (i_reset) begin
            syncS1   <= '0;
            syncS2   <= '0;
            debLevel <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                debCnt[i] <= '0;
            end
        end else begin
            syncS1 <= btnRaw;
            syncS2 <= syncS1;
            for (int i = 0; i < NumBtn; i++) begin
                if (syncS2[i] != debLevel[i]) begin
                    if (debCnt[i] == CntLast) begin
                        debLevel[i] <= syncS2[i];
                        debCnt[i]   <= '0;
                    end else begin
                        debCnt[i] <= debCnt[i] + CntW'(1);
                    end
                end else begin
                    debCnt[i] <= '0;
                end
            end
        end
    end

    // A press is the edge on which the debounced level is about to go 0->1
    always_comb begin
        pressC = '0;
        for (int i = 0; i < NumBtn; i++) begin
            pressC[i] = syncS2[i] & ~debLevel[i] & (debCnt[i] == CntLast);
        end
    end

    // Fixed priority A > B > OP; losers are dropped, not deferred
    always_comb begin
        loadA      = pressC[0];
        loadB      = pressC[1] & ~pressC[0];
        loadOp     = pressC[2] & ~pressC[1] & ~pressC[0];
        loadedNext = o_loaded | {loadOp, loadB, loadA};
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_op     <= '0;
            o_loaded <= '0;
            o_valid  <= 1'b0;
            o_start  <= 1'b0;
        end else begin
            if (loadA) begin
                o_data_a <= i_sw;
            end
            if (loadB) begin
                o_data_b <= i_sw;
            end
            if (loadOp) begin
                o_op <= i_sw[NB_OP-1:0];
            end
            o_loaded <= loadedNext;
            o_valid  <= &loadedNext;
            // Strobe only when both operands were already present before this opcode
            o_start  <= loadOp & o_loaded[0] & o_loaded[1];
        end
    end

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Scoreboard bench for alu_input_ctrl: stimulus queues expected output snapshots,
// a monitor pops one whenever the outputs change or a start strobe appears.
module tb_alu_input_ctrl;

    localparam int unsigned D = 4;

    typedef struct packed {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [2:0] ld;
        logic       v;
        logic       s;
    } exp_t;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [7:0] swReg;
    logic [2:0] btn;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic [2:0] o_loaded;
    logic       o_valid;
    logic       o_start;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic monOn = 1'b0;
    logic probe = 1'b0;
    logic done = 1'b0;
    exp_t q[$];

    logic [7:0] mA;
    logic [7:0] mB;
    logic [5:0] mOp;
    logic [2:0] mLd;

    alu_input_ctrl dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (swReg),
        .i_btn_a  (btn[0]),
        .i_btn_b  (btn[1]),
        .i_btn_op (btn[2]),
        .o_data_a (o_data_a),
        .o_data_b (o_data_b),
        .o_op     (o_op),
        .o_loaded (o_loaded),
        .o_valid  (o_valid),
        .o_start  (o_start)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void pushExp(input int c, input logic s);
        exp_t e;
        e.cyc = c;
        e.a   = mA;
        e.b   = mB;
        e.op  = mOp;
        e.ld  = mLd;
        e.v   = &mLd;
        e.s   = s;
        q.push_back(e);
    endfunction

    task automatic waitN(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raw press held for 'hold' cycles; 'accepted' predicts a load at edge D+1
    task automatic doPress(input int which, input logic [7:0] sw, input int hold, input logic accepted);
        int c;
        logic strobe;
        @(negedge clock);
        swReg = sw;
        btn[which] = 1'b1;
        c = cyc;
        if (accepted) begin
            strobe = (which == 2) && mLd[0] && mLd[1];
            case (which)
                0:       mA  = sw;
                1:       mB  = sw;
                default: mOp = sw[5:0];
            endcase
            mLd[which] = 1'b1;
            pushExp(c + D + 2, strobe);
            if (strobe) pushExp(c + D + 3, 1'b0);
        end
        waitN(hold);
        btn[which] = 1'b0;
        waitN(D + 4);
    endtask

    task automatic doReset();
        @(negedge clock);
        i_reset = 1'b1;
        mA = '0; mB = '0; mOp = '0; mLd = '0;
        pushExp(cyc + 1, 1'b0);
        @(negedge clock);
        i_reset = 1'b0;
    endtask

    task automatic chatterA(input logic [7:0] sw);
        @(negedge clock);
        swReg = sw;
        btn[0] = 1'b1;
        waitN(2);
        btn[0] = 1'b0;
        waitN(1);
        btn[0] = 1'b1;
        waitN(2);
        btn[0] = 1'b0;
        waitN(D + 4);
    endtask

    // A and OP rise together: only A may load
    task automatic pressAandOp(input logic [7:0] sw);
        int c;
        @(negedge clock);
        swReg = sw;
        btn = 3'b101;
        c = cyc;
        mA = sw;
        mLd[0] = 1'b1;
        pushExp(c + D + 2, 1'b0);
        waitN(D + 4);
        btn = 3'b000;
        waitN(D + 4);
    endtask

    // Reset hits at edge 3 of an A press that stays held through and after reset
    task automatic resetMidCount(input logic [7:0] sw);
        int c;
        @(negedge clock);
        swReg = sw;
        btn[0] = 1'b1;
        c = cyc;
        waitN(3);
        i_reset = 1'b1;
        mA = '0; mB = '0; mOp = '0; mLd = '0;
        pushExp(c + 4, 1'b0);
        @(negedge clock);
        i_reset = 1'b0;
        mA = sw;
        mLd[0] = 1'b1;
        pushExp(c + 4 + D + 2, 1'b0);
        waitN(D + 8);
        btn[0] = 1'b0;
        waitN(D + 4);
    endtask

    initial begin
        logic [7:0] ops [8];
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        i_reset = 1'b1;
        btn = '0;
        swReg = '0;
        mA = '0; mB = '0; mOp = '0; mLd = '0;
        waitN(3);
        i_reset = 1'b0;
        @(posedge clock);
        pushExp(-1, 1'b0);
        probe = 1'b1;
        monOn = 1'b1;
        @(negedge clock);
        #1 probe = 1'b0;

        doPress(0, 8'hFF, D + 4, 1'b1);
        doPress(1, 8'h02, D + 4, 1'b1);
        doPress(2, 8'h20, D + 4, 1'b1);

        doPress(0, 8'hAA, 3, 1'b0);
        chatterA(8'hCC);
        doPress(0, 8'h5A, D, 1'b1);

        doReset();
        doPress(0, 8'h11, D + 4, 1'b1);
        doPress(2, 8'h22, D + 4, 1'b1);
        doPress(1, 8'h33, D + 4, 1'b1);
        doPress(2, 8'h22, D + 4, 1'b1);

        doReset();
        pressAandOp(8'h44);
        doPress(2, 8'h15, D + 4, 1'b1);
        doPress(1, 8'h66, D + 4, 1'b1);

        for (int i = 0; i < 8; i++) begin
            doPress(2, ops[i], D + 4, 1'b1);
        end

        resetMidCount(8'h77);

        waitN(4);
        done = 1'b1;
    end

    // Monitor: every output change, strobe or explicit probe consumes one expectation
    initial begin
        logic [26:0] cur;
        logic [26:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clock);
            cur = {o_data_a, o_data_b, o_op, o_loaded, o_valid, o_start};
            if (monOn && (cur !== prev || o_start || probe)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got a=%h b=%h op=%h ld=%b v=%b s=%b",
                             cyc, o_data_a, o_data_b, o_op, o_loaded, o_valid, o_start);
                end else begin
                    e = q.pop_front();
                    if (cur !== {e.a, e.b, e.op, e.ld, e.v, e.s} || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL event cyc=%0d got a=%h b=%h op=%h ld=%b v=%b s=%b, need cyc=%0d a=%h b=%h op=%h ld=%b v=%b s=%b",
                                 cyc, o_data_a, o_data_b, o_op, o_loaded, o_valid, o_start,
                                 e.cyc, e.a, e.b, e.op, e.ld, e.v, e.s);
                    end
                end
            end
            prev = cur;
            if (cyc > 20000) begin
                errors++;
                $display("FAIL timeout cyc=%0d pending=%0d need 0", cyc, q.size());
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (done) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events pending=%0d need 0", q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

endmodule
